// File: rtl/hb_pkg.sv
// Shared types and default constants for the H-bridge drive controller.
package hb_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } hb_state_e;

    localparam int HB_PWM_BITS    = 8;
    localparam int HB_PRESCALE    = 16;
    localparam int HB_DEAD_CYCLES = 100000;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/hb_pwm_gen.sv
// PWM generator: prescaler, period counter, period-boundary duty latch and registered compare.
module hb_pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic [PWM_BITS-1:0] load_duty,
    input  logic [PWM_BITS-1:0] duty_next,
    input  logic                gate,
    output logic                pwm
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_active;
    logic                step;
    logic                wrap;

    assign step = (pre_cnt == PRE_LAST);
    assign wrap = step && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            duty_active <= '0;
            pwm         <= 1'b0;
        end else begin
            if (clear) begin
                pre_cnt <= '0;
                pwm_cnt <= '0;
            end else begin
                pre_cnt <= step ? '0 : pre_cnt + 1'b1;
                if (step) begin
                    pwm_cnt <= pwm_cnt + 1'b1;
                end
            end
            // An explicit load (reversal entry/exit) overrides the boundary latch.
            if (load) begin
                duty_active <= load_duty;
            end else if (!clear && wrap) begin
                duty_active <= duty_next;
            end
            pwm <= gate && (pwm_cnt < duty_active);
        end
    end

endmodule

// File: rtl/hbridge_drive_ctrl.sv
// One H-bridge channel: command handshake, direction-reversal dead-time FSM and PWM drive.
module hbridge_drive_ctrl
    import hb_pkg::*;
#(
    parameter int PWM_BITS    = HB_PWM_BITS,
    parameter int PRESCALE    = HB_PRESCALE,
    parameter int DEAD_CYCLES = HB_DEAD_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [PWM_BITS-1:0] cmd_duty,
    output logic                hb_en,
    output logic                hb_dir,
    output logic                busy
);

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    hb_state_e           state;
    hb_state_e           state_next;
    logic [DEAD_W-1:0]   dead_cnt;
    logic                dir_pending;
    logic [PWM_BITS-1:0] duty_pending;

    logic                accept;
    logic                reversing;
    logic                dead_done;
    logic                pwm_clear;
    logic                pwm_load;
    logic                pwm_gate;
    logic [PWM_BITS-1:0] load_duty;

    assign accept    = cmd_valid && (state == RUN);
    assign reversing = accept && (cmd_dir != hb_dir);
    assign dead_done = (state == DEAD) && (dead_cnt == DEAD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (reversing) state_next = DEAD;
            DEAD:    if (dead_done) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Entering or exiting dead-time reloads the duty immediately and restarts the period.
    always_comb begin
        cmd_ready = (state == RUN);
        busy      = (state == DEAD);
        pwm_clear = (state == DEAD) || reversing;
        pwm_load  = reversing || dead_done;
        load_duty = dead_done ? duty_pending : '0;
        pwm_gate  = enable && (state == RUN) && !reversing;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dead_cnt     <= '0;
            dir_pending  <= DIR_FWD;
            duty_pending <= '0;
            hb_dir       <= DIR_FWD;
        end else begin
            if (reversing) begin
                dead_cnt <= '0;
            end else if (state == DEAD) begin
                dead_cnt <= dead_cnt + 1'b1;
            end
            if (accept) begin
                duty_pending <= cmd_duty;
            end
            if (reversing) begin
                dir_pending <= cmd_dir;
            end
            if (dead_done) begin
                hb_dir <= dir_pending;
            end
        end
    end

    hb_pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk       (clk),
        .reset     (reset),
        .clear     (pwm_clear),
        .load      (pwm_load),
        .load_duty (load_duty),
        .duty_next (duty_pending),
        .gate      (pwm_gate),
        .pwm       (hb_en)
    );

endmodule

// File: tb/tb_hbridge_drive_ctrl.sv
// Bench for hbridge_drive_ctrl: cycle scoreboard plus per-scenario pulse-shape checks.
module tb_hbridge_drive_ctrl;

    localparam int PB = 4;
    localparam int PS = 1;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [PB-1:0] cmd_duty = '0;
    logic          hb_en;
    logic          hb_dir;
    logic          busy;

    int errors = 0;
    int checks = 0;

    hbridge_drive_ctrl #(
        .PWM_BITS    (PB),
        .PRESCALE    (PS),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_duty  (cmd_duty),
        .hb_en     (hb_en),
        .hb_dir    (hb_dir),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference state, advanced once per clock from the inputs present before the edge.
    logic          m_dead_st;
    int            m_dead;
    int            m_pre;
    logic [PB-1:0] m_pwm;
    logic [PB-1:0] m_dutya;
    logic [PB-1:0] m_dutyp;
    logic          m_dirp;
    logic          m_en;
    logic          m_dir;

    logic [3:0] exp_q[$];

    task automatic model_step();
        logic          n_st;
        int            n_dead;
        int            n_pre;
        logic [PB-1:0] n_pwm;
        logic [PB-1:0] n_dutya;
        logic [PB-1:0] n_dutyp;
        logic          n_dirp;
        logic          n_en;
        logic          n_dir;
        if (reset) begin
            m_dead_st = 1'b0; m_dead = 0; m_pre = 0; m_pwm = '0;
            m_dutya = '0; m_dutyp = '0; m_dirp = 1'b0; m_en = 1'b0; m_dir = 1'b0;
            return;
        end
        n_st = m_dead_st; n_dead = m_dead; n_pre = m_pre; n_pwm = m_pwm;
        n_dutya = m_dutya; n_dutyp = m_dutyp; n_dirp = m_dirp; n_dir = m_dir;
        if (!m_dead_st) begin
            n_en = enable && (m_pwm < m_dutya);
            if (m_pre == PS - 1) begin
                n_pre = 0;
                n_pwm = m_pwm + 1'b1;
                if (m_pwm == 4'd15) n_dutya = m_dutyp;
            end else begin
                n_pre = m_pre + 1;
            end
            if (cmd_valid && cmd_dir == m_dir) begin
                n_dutyp = cmd_duty;
            end else if (cmd_valid) begin
                n_st = 1'b1; n_dead = 0; n_dirp = cmd_dir; n_dutyp = cmd_duty;
                n_dutya = '0; n_en = 1'b0; n_pre = 0; n_pwm = '0;
            end
        end else begin
            n_en = 1'b0; n_dead = m_dead + 1; n_pre = 0; n_pwm = '0;
            if (m_dead == DC - 1) begin
                n_dir = m_dirp; n_dutya = m_dutyp; n_st = 1'b0;
            end
        end
        m_dead_st = n_st; m_dead = n_dead; m_pre = n_pre; m_pwm = n_pwm;
        m_dutya = n_dutya; m_dutyp = n_dutyp; m_dirp = n_dirp; m_en = n_en; m_dir = n_dir;
    endtask

    task automatic tick();
        model_step();
        exp_q.push_back({m_en, m_dir, m_dead_st, ~m_dead_st});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({hb_en, hb_dir, busy, cmd_ready} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t {en,dir,busy,ready} got=%b expected=%b",
                         $time, {hb_en, hb_dir, busy, cmd_ready}, e);
            end
        end
    end

    task automatic send(input logic dir, input logic [PB-1:0] duty);
        cmd_dir = dir;
        cmd_duty = duty;
        cmd_valid = 1'b1;
        tick();
    endtask

    // Skips to the next rising hb_en, then returns the length of that high run.
    task automatic measure_run(output int len);
        int n;
        len = -1;
        n = 0;
        while (hb_en !== 1'b0 && n < 40) begin tick(); n++; end
        n = 0;
        while (hb_en !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (hb_en !== 1'b1) begin
            errors++;
            $display("FAIL run_timeout hb_en got=%b required=1 within 40 cycles", hb_en);
            return;
        end
        len = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hb_en) len++;
            else break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({hb_en, hb_dir, busy, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=0001", {hb_en, hb_dir, busy, cmd_ready});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_pwm();
        int len;
        send(1'b0, 4'd8);
        measure_run(len);
        checks++;
        if (len != 8) begin errors++; $display("FAIL basic_run_len got=%0d required=8", len); end
        measure_run(len);
        checks++;
        if (len != 8) begin errors++; $display("FAIL basic_run_len2 got=%0d required=8", len); end
        checks++;
        if (hb_dir !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_dir_ready got=%b%b required=01", hb_dir, cmd_ready);
        end
    endtask

    task automatic test_duty_change();
        int c;
        int n;
        int len;
        n = 0;
        while (hb_en !== 1'b0 && n < 40) begin tick(); n++; end
        n = 0;
        while (hb_en !== 1'b1 && n < 40) begin tick(); n++; end
        c = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin
                cmd_dir = 1'b0; cmd_duty = 4'd12; cmd_valid = 1'b1;
            end
            tick();
            if (hb_en) c++;
            else break;
        end
        checks++;
        if (c != 8) begin errors++; $display("FAIL change_cur_period got=%0d required=8", c); end
        measure_run(len);
        checks++;
        if (len != 12) begin errors++; $display("FAIL change_next_period got=%0d required=12", len); end
    endtask

    task automatic test_back_to_back();
        int len;
        send(1'b0, 4'd2);
        send(1'b0, 4'd10);
        measure_run(len);
        checks++;
        if (len != 10) begin errors++; $display("FAIL last_wins got=%0d required=10", len); end
    endtask

    task automatic test_reversal();
        int c;
        send(1'b1, 4'd4);
        checks++;
        if ({hb_en, busy, cmd_ready} !== 3'b010) begin
            errors++;
            $display("FAIL rev_accept {en,busy,ready} got=%b required=010", {hb_en, busy, cmd_ready});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || hb_dir !== 1'b0) begin
                errors++;
                $display("FAIL rev_dead busy/dir got=%b%b required=10", busy, hb_dir);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || hb_dir !== 1'b1) begin
            errors++;
            $display("FAIL rev_exit busy/dir got=%b%b required=01", busy, hb_dir);
        end
        tick();
        c = 0;
        for (int i = 0; i < 20; i++) begin
            if (hb_en) c++;
            else break;
            tick();
        end
        checks++;
        if (c != 4) begin errors++; $display("FAIL rev_restart_run got=%0d required=4", c); end
    endtask

    task automatic test_dead_hold();
        logic [9:0] seq;
        int len;
        send(1'b0, 4'd6);
        seq[9] = busy;
        cmd_dir = 1'b1; cmd_duty = 4'd5;
        for (int i = 8; i >= 0; i--) begin
            cmd_valid = (i >= 4);
            tick();
            seq[i] = busy;
            if (i == 5) begin
                checks++;
                if (hb_dir !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_mid_dir got=%b required=0", hb_dir);
                end
            end
        end
        checks++;
        if (seq !== 10'b1111011110) begin
            errors++;
            $display("FAIL hold_busy_seq got=%b required=1111011110", seq);
        end
        checks++;
        if (hb_dir !== 1'b1) begin errors++; $display("FAIL hold_final_dir got=%b required=1", hb_dir); end
        measure_run(len);
        checks++;
        if (len != 5) begin errors++; $display("FAIL hold_run got=%0d required=5", len); end
    endtask

    task automatic test_enable();
        int len;
        int c;
        send(1'b1, 4'd15);
        measure_run(len);
        checks++;
        if (len != 15) begin errors++; $display("FAIL max_duty_run got=%0d required=15", len); end
        tick();
        tick();
        enable = 1'b0;
        tick();
        checks++;
        if (hb_en !== 1'b0) begin errors++; $display("FAIL enable_off got=%b required=0", hb_en); end
        c = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (hb_en) c++; end
        checks++;
        if (c != 0) begin errors++; $display("FAIL enable_off_hold got=%0d required=0", c); end
        enable = 1'b1;
        tick();
        checks++;
        if (hb_en !== 1'b1) begin errors++; $display("FAIL enable_resume got=%b required=1", hb_en); end
        measure_run(len);
        checks++;
        if (len != 15) begin errors++; $display("FAIL enable_resume_run got=%0d required=15", len); end
    endtask

    task automatic test_reset_dead();
        int c;
        send(1'b0, 4'd3);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({hb_en, hb_dir, busy, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_in_dead got=%b required=0001", {hb_en, hb_dir, busy, cmd_ready});
        end
        reset = 1'b0;
        send(1'b0, 4'd0);
        c = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (hb_en) c++; end
        checks++;
        if (c != 0) begin errors++; $display("FAIL duty_zero got=%0d required=0", c); end
    endtask

    initial begin
        test_reset();
        test_basic_pwm();
        test_duty_change();
        test_back_to_back();
        test_reversal();
        test_dead_hold();
        test_enable();
        test_reset_dead();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
